// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path.
//   cap_state_t : capture sequencer states
//   NUM_CH      : number of per-channel trigger stages feeding the controller
package la_pkg;

    localparam int NUM_CH = 5;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/smpl_addr_ctr.sv
// Wrap-around sample RAM write-address counter.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears the address to 0
//   inc   : advance the address by one this cycle
//   addr  : current write address, wraps modulo 2**ADDR_W
module smpl_addr_ctr #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_reg;

    // Natural overflow of the ADDR_W-bit register gives the circular wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (inc) begin
            addr_reg <= addr_reg + 1'b1;
        end
    end

    assign addr = addr_reg;

endmodule

// File: rtl/capture_ctrl.sv
// Sample-capture controller.
// Fills the circular sample RAM with pre-trigger history, arms the channel
// trigger stages, waits for the combined trigger, captures the post-trigger
// samples and reports the address of the final post-trigger write.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, abort : one-cycle control pulses (abort has priority)
//   wrt_smpl     : decimated sample strobe
//   trig_pos     : number of samples kept after the trigger (0 behaves as 1)
//   ch_trig      : per-channel trigger qualifiers (1 = satisfied/don't care)
//   prot_trig    : protocol trigger qualifier (1 = satisfied/don't care)
//   we, waddr    : sample RAM write enable / address
//   set_armed    : arms the channel stages; low clears their edge catchers
//   triggered    : trigger seen in the current capture
//   capture_done : capture complete (sticky until start/abort)
//   trig_addr    : address of the last post-trigger sample
module capture_ctrl
    import la_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              wrt_smpl,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [NUM_CH-1:0] ch_trig,
    input  logic              prot_trig,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              set_armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr
);

    // Counts are one bit wider than the address so DEPTH itself is representable.
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    cap_state_t        state_reg,     state_next;
    logic [ADDR_W:0]   smpl_cnt_reg,  smpl_cnt_next;
    logic [ADDR_W:0]   post_cnt_reg,  post_cnt_next;
    logic              set_armed_reg, set_armed_next;
    logic              triggered_reg, triggered_next;
    logic              done_reg,      done_next;
    logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;

    logic [ADDR_W:0]   tp_eff;
    logic [ADDR_W:0]   pre_cnt;
    logic [ADDR_W:0]   smpl_cnt_inc;
    logic [ADDR_W:0]   post_cnt_inc;
    logic              trig_all;
    logic              capturing;

    // A zero trigger position still keeps one post-trigger sample so the
    // capture always terminates.
    assign tp_eff       = (trig_pos == '0) ? ONE_C : {1'b0, trig_pos};
    assign pre_cnt      = DEPTH_C - tp_eff;
    assign smpl_cnt_inc = smpl_cnt_reg + ONE_C;
    assign post_cnt_inc = post_cnt_reg + ONE_C;

    assign capturing = (state_reg == PRE) || (state_reg == ARMED) || (state_reg == POST);
    assign we        = wrt_smpl & capturing;

    // Gating with set_armed keeps a stale qualifier from firing before the
    // channel stages have actually been armed.
    assign trig_all = (&ch_trig) & prot_trig & set_armed_reg;

    smpl_addr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (we),
        .addr  (waddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            smpl_cnt_reg  <= '0;
            post_cnt_reg  <= '0;
            set_armed_reg <= 1'b0;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
            trig_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            smpl_cnt_reg  <= smpl_cnt_next;
            post_cnt_reg  <= post_cnt_next;
            set_armed_reg <= set_armed_next;
            triggered_reg <= triggered_next;
            done_reg      <= done_next;
            trig_addr_reg <= trig_addr_next;
        end
    end

    // Count compares use >= so a trig_pos change mid-capture can only change
    // the capture length, never strand the sequencer.
    always_comb begin
        state_next     = state_reg;
        smpl_cnt_next  = smpl_cnt_reg;
        post_cnt_next  = post_cnt_reg;
        set_armed_next = set_armed_reg;
        triggered_next = triggered_reg;
        done_next      = done_reg;
        trig_addr_next = trig_addr_reg;

        if (abort) begin
            state_next     = IDLE;
            set_armed_next = 1'b0;
            triggered_next = 1'b0;
            done_next      = 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next     = PRE;
                        smpl_cnt_next  = '0;
                        triggered_next = 1'b0;
                        done_next      = 1'b0;
                    end
                end
                PRE: begin
                    if (we) begin
                        smpl_cnt_next = smpl_cnt_inc;
                        if (smpl_cnt_inc >= pre_cnt) begin
                            state_next     = ARMED;
                            set_armed_next = 1'b1;
                        end
                    end
                end
                ARMED: begin
                    // A write in this same cycle belongs to the pre-trigger history.
                    if (trig_all) begin
                        triggered_next = 1'b1;
                        post_cnt_next  = '0;
                        state_next     = POST;
                    end
                end
                POST: begin
                    if (we) begin
                        post_cnt_next = post_cnt_inc;
                        if (post_cnt_inc >= tp_eff) begin
                            trig_addr_next = waddr;
                            done_next      = 1'b1;
                            set_armed_next = 1'b0;
                            state_next     = DONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign set_armed    = set_armed_reg;
    assign triggered    = triggered_reg;
    assign capture_done = done_reg;
    assign trig_addr    = trig_addr_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          wrt_smpl = 1'b0;
    logic [AW-1:0] trig_pos = '0;
    logic [4:0]    ch_trig = '0;
    logic          prot_trig = 1'b0;
    logic          we;
    logic [AW-1:0] waddr;
    logic          set_armed;
    logic          triggered;
    logic          capture_done;
    logic [AW-1:0] trig_addr;

    capture_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .wrt_smpl     (wrt_smpl),
        .trig_pos     (trig_pos),
        .ch_trig      (ch_trig),
        .prot_trig    (prot_trig),
        .we           (we),
        .waddr        (waddr),
        .set_armed    (set_armed),
        .triggered    (triggered),
        .capture_done (capture_done),
        .trig_addr    (trig_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int waddr;
        bit armed;
        bit trig;
        bit done;
        int taddr;
    } stat_t;

    typedef struct {
        int cyc;
        int addr;
    } wr_t;

    stat_t sq[$];
    wr_t   wq[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: a capture is a running flag plus counts of writes
    // before and after the trigger, with the RAM address as a plain integer.
    bit m_run  = 0;
    bit m_trig = 0;
    bit m_done = 0;
    int m_pre  = 0;
    int m_post = 0;
    int m_waddr = 0;
    int m_taddr = 0;

    function automatic int post_len(input int tp);
        return (tp == 0) ? 1 : tp;
    endfunction

    task automatic model_reset();
        m_run = 0; m_trig = 0; m_done = 0;
        m_pre = 0; m_post = 0; m_waddr = 0; m_taddr = 0;
    endtask

    task automatic step(input bit s, input bit a, input bit w, input logic [AW-1:0] tp,
                        input logic [4:0] ch, input bit p);
        stat_t st;
        wr_t   wr;
        int    keep_after;
        int    keep_before;
        bit    armed_now;
        bit    wrote;
        @(posedge clk);
        #1;
        start = s; abort = a; wrt_smpl = w; trig_pos = tp; ch_trig = ch; prot_trig = p;
        cyc++;
        keep_after  = post_len(int'(tp));
        keep_before = DEPTH - keep_after;
        armed_now   = m_run && (m_pre >= keep_before);
        wrote       = w && m_run;
        st = '{cyc, m_waddr, armed_now, m_trig, m_done, m_taddr};
        sq.push_back(st);
        if (wrote) begin
            wr = '{cyc, m_waddr};
            wq.push_back(wr);
        end
        if (a) begin
            m_run = 0; m_trig = 0; m_done = 0;
        end else if (s && !m_run) begin
            m_run = 1; m_trig = 0; m_done = 0; m_pre = 0; m_post = 0;
        end else if (m_run && !m_trig) begin
            if (armed_now && (&ch) && p) begin
                m_trig = 1;
                m_post = 0;
            end else if (wrote && !armed_now) begin
                m_pre++;
            end
        end else if (m_run && m_trig && wrote) begin
            m_post++;
            if (m_post >= keep_after) begin
                m_taddr = m_waddr;
                m_done  = 1;
                m_run   = 0;
            end
        end
        if (wrote) m_waddr = (m_waddr + 1) % DEPTH;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({we, waddr, set_armed, triggered, capture_done, trig_addr} !== '0) begin
            miscompares++;
            $display("FAIL %s: got we=%b waddr=%0d armed=%b trig=%b done=%b taddr=%0d, expected all 0",
                     tag, we, waddr, set_armed, triggered, capture_done, trig_addr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: status every cycle, write transactions whenever the DUT writes.
    initial begin
        stat_t st;
        wr_t   wr;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                st = sq.pop_front();
                vectors++;
                if (int'(waddr) != st.waddr || set_armed !== st.armed || triggered !== st.trig ||
                    capture_done !== st.done || int'(trig_addr) != st.taddr) begin
                    miscompares++;
                    $display("FAIL status cyc=%0d: got waddr=%0d armed=%b trig=%b done=%b taddr=%0d, expected waddr=%0d armed=%b trig=%b done=%b taddr=%0d",
                             st.cyc, waddr, set_armed, triggered, capture_done, trig_addr,
                             st.waddr, st.armed, st.trig, st.done, st.taddr);
                end
            end
            if (we !== 1'b0) begin
                vectors++;
                if (wq.size() == 0) begin
                    miscompares++;
                    $display("FAIL write cyc=%0d: got unexpected write we=%b addr=%0d, expected no write",
                             cyc, we, waddr);
                end else begin
                    wr = wq.pop_front();
                    if (wr.cyc != cyc || wr.addr != int'(waddr)) begin
                        miscompares++;
                        $display("FAIL write: got cyc=%0d addr=%0d, expected cyc=%0d addr=%0d",
                                 cyc, waddr, wr.cyc, wr.addr);
                    end
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] tp;
        logic [4:0]    ch;
        bit            s, a;

        #2 check_reset_outputs("initial_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Pre-trigger fill, no qualifier satisfied.
        step(1, 0, 0, 3'd3, 5'b00000, 1);
        repeat (10) step(0, 0, 1, 3'd3, 5'b00000, 1);
        // Trigger pulse, then post capture.
        step(0, 0, 1, 3'd3, 5'b11111, 1);
        repeat (6) step(0, 0, 1, 3'd3, 5'b00000, 1);

        // Partial qualifier held while armed: must wrap without triggering.
        step(1, 0, 1, 3'd3, 5'b11011, 1);
        repeat (15) step(0, 0, 1, 3'd3, 5'b11011, 1);
        // Trigger, one post write, abort, then strobes that must not write.
        step(0, 0, 1, 3'd3, 5'b11111, 1);
        step(0, 0, 1, 3'd3, 5'b00000, 1);
        step(0, 1, 0, 3'd3, 5'b00000, 1);
        repeat (4) step(0, 0, 1, 3'd3, 5'b11111, 1);

        // Zero trigger position: 7 pre writes, 1 post write.
        step(1, 0, 1, 3'd0, 5'b11111, 1);
        repeat (12) step(0, 0, 1, 3'd0, 5'b11111, 1);
        // Start together with abort stays idle.
        step(1, 1, 1, 3'd0, 5'b11111, 1);
        repeat (4) step(0, 0, 1, 3'd0, 5'b11111, 1);

        // Asynchronous reset in the middle of a capture.
        step(1, 0, 1, 3'd2, 5'b00000, 1);
        repeat (3) step(0, 0, 1, 3'd2, 5'b00000, 1);
        do_reset();

        // Randomised traffic.
        tp = 3'd4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (!m_run) tp = 3'($urandom_range(0, 7));
            ch = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b11111;
            s  = ($urandom_range(0, 7) == 0);
            a  = ($urandom_range(0, 59) == 0);
            step(s, a, bit'($urandom_range(0, 1)), tp, ch, bit'($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        vectors++;
        if (wq.size() != 0 || sq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d writes and %0d status records outstanding, expected 0 and 0",
                     wq.size(), sq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
